// File: rtl/mem_arb_pkg.sv
// Shared types for the RAM arbiter: FSM state encoding, owner IDs and the
// wait-counter preload helper.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ARB   = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_LDR = 1'b1
   } owner_t;

   localparam int CNT_W = 2;

   // WAIT lasts RAM_LAT cycles, counting down to zero before the capture edge.
   function automatic logic [CNT_W-1:0] wait_count(input int lat);
      return CNT_W'(lat - 1);
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester always wins; on contention the
// requester that was not granted last wins.
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic   i_req_a,
   input  logic   i_req_b,
   input  owner_t i_last,
   output logic   o_grant_valid,
   output owner_t o_winner
);

   always_comb begin
      o_grant_valid = i_req_a | i_req_b;
      o_winner      = OWN_CPU;
      if (i_req_a && i_req_b) begin
         o_winner = (i_last == OWN_CPU) ? OWN_LDR : OWN_CPU;
      end else if (i_req_b) begin
         o_winner = OWN_LDR;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port synchronous RAM between the CPU memory path and the
// loader port; one transaction in flight, registered RAM command outputs.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 9,
   parameter int DATA_W  = 32,
   parameter int RAM_LAT = 1
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Stop,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic              ldr_gnt,
   output logic              ldr_rvalid,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy
);

   // Handshake: a requester holds req/we/addr/wdata until it sees its gnt high
   // for one cycle; a read answers later with a one-cycle rvalid pulse.
   localparam logic [CNT_W-1:0] CNT_INIT = wait_count(RAM_LAT);

   arb_state_t         r_state;
   owner_t             r_last_grant;
   owner_t             r_owner;
   logic               r_is_read;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_cpu_gnt;
   logic               r_ldr_gnt;
   logic               r_cpu_rvalid;
   logic               r_ldr_rvalid;
   logic [DATA_W-1:0]  r_cpu_rdata;
   logic [DATA_W-1:0]  r_ldr_rdata;
   logic [ADDR_W-1:0]  r_ram_addr;
   logic [DATA_W-1:0]  r_ram_wdata;
   logic               r_ram_we;

   logic               w_grant_valid;
   owner_t             w_winner;
   logic               w_win_we;
   logic [ADDR_W-1:0]  w_win_addr;
   logic [DATA_W-1:0]  w_win_wdata;

   rr_pick2 u_pick (
      .i_req_a       (cpu_req),
      .i_req_b       (ldr_req),
      .i_last        (r_last_grant),
      .o_grant_valid (w_grant_valid),
      .o_winner      (w_winner)
   );

   always_comb begin
      w_win_we    = cpu_we;
      w_win_addr  = cpu_addr;
      w_win_wdata = cpu_wdata;
      if (w_winner == OWN_LDR) begin
         w_win_we    = ldr_we;
         w_win_addr  = ldr_addr;
         w_win_wdata = ldr_wdata;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_state      <= ARB;
         r_last_grant <= OWN_LDR;
         r_owner      <= OWN_CPU;
         r_is_read    <= 1'b0;
         r_cnt        <= '0;
         r_cpu_gnt    <= 1'b0;
         r_ldr_gnt    <= 1'b0;
         r_cpu_rvalid <= 1'b0;
         r_ldr_rvalid <= 1'b0;
         r_cpu_rdata  <= '0;
         r_ldr_rdata  <= '0;
         r_ram_addr   <= '0;
         r_ram_wdata  <= '0;
         r_ram_we     <= 1'b0;
      end else begin
         case (r_state)
            ARB: begin
               // Stop only gates new grants; it is never looked at mid-transaction.
               if (!Stop && w_grant_valid) begin
                  r_ram_addr   <= w_win_addr;
                  r_ram_wdata  <= w_win_wdata;
                  r_ram_we     <= w_win_we;
                  r_cpu_gnt    <= (w_winner == OWN_CPU);
                  r_ldr_gnt    <= (w_winner == OWN_LDR);
                  r_last_grant <= w_winner;
                  r_owner      <= w_winner;
                  r_is_read    <= ~w_win_we;
                  r_state      <= ISSUE;
               end
            end
            ISSUE: begin
               r_cpu_gnt <= 1'b0;
               r_ldr_gnt <= 1'b0;
               r_ram_we  <= 1'b0;
               if (r_is_read) begin
                  r_cnt   <= CNT_INIT;
                  r_state <= WAIT;
               end else begin
                  r_state <= ARB;
               end
            end
            WAIT: begin
               if (r_cnt == '0) begin
                  if (r_owner == OWN_CPU) begin
                     r_cpu_rdata  <= ram_rdata;
                     r_cpu_rvalid <= 1'b1;
                  end else begin
                     r_ldr_rdata  <= ram_rdata;
                     r_ldr_rvalid <= 1'b1;
                  end
                  r_state <= RESP;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            RESP: begin
               r_cpu_rvalid <= 1'b0;
               r_ldr_rvalid <= 1'b0;
               r_state      <= ARB;
            end
            default: r_state <= ARB;
         endcase
      end
   end

   assign cpu_gnt    = r_cpu_gnt;
   assign ldr_gnt    = r_ldr_gnt;
   assign cpu_rvalid = r_cpu_rvalid;
   assign ldr_rvalid = r_ldr_rvalid;
   assign cpu_rdata  = r_cpu_rdata;
   assign ldr_rdata  = r_ldr_rdata;
   assign ram_addr   = r_ram_addr;
   assign ram_wdata  = r_ram_wdata;
   assign ram_we     = r_ram_we;
   assign busy       = (r_state != ARB);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM models for RAM_LAT=1 and RAM_LAT=3 instances,
// a shadow memory and round-robin model, and one task per scenario.
module tb_mem_arbiter;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        Stop;
   logic        cpu_req, cpu_we, ldr_req, ldr_we;
   logic [8:0]  cpu_addr, ldr_addr, ram_addr;
   logic [31:0] cpu_wdata, ldr_wdata, ram_wdata, ram_rdata;
   logic        cpu_gnt, cpu_rvalid, ldr_gnt, ldr_rvalid, ram_we, busy;
   logic [31:0] cpu_rdata, ldr_rdata;

   logic        cpu_req_3, cpu_we_3, ldr_req_3, ldr_we_3;
   logic [8:0]  cpu_addr_3, ldr_addr_3, ram_addr_3;
   logic [31:0] cpu_wdata_3, ldr_wdata_3, ram_wdata_3, ram_rdata_3;
   logic        cpu_gnt_3, cpu_rvalid_3, ldr_gnt_3, ldr_rvalid_3, ram_we_3, busy_3;
   logic [31:0] cpu_rdata_3, ldr_rdata_3;

   always #5 Clock = ~Clock;

   int cyc = 0;
   always @(posedge Clock) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.ADDR_W(9), .DATA_W(32), .RAM_LAT(1)) u_dut (
      .Clock(Clock), .Reset(Reset), .Stop(Stop),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
      .ram_rdata(ram_rdata), .busy(busy)
   );

   mem_arbiter #(.ADDR_W(9), .DATA_W(32), .RAM_LAT(3)) u_dut3 (
      .Clock(Clock), .Reset(Reset), .Stop(Stop),
      .cpu_req(cpu_req_3), .cpu_we(cpu_we_3), .cpu_addr(cpu_addr_3), .cpu_wdata(cpu_wdata_3),
      .cpu_gnt(cpu_gnt_3), .cpu_rvalid(cpu_rvalid_3), .cpu_rdata(cpu_rdata_3),
      .ldr_req(ldr_req_3), .ldr_we(ldr_we_3), .ldr_addr(ldr_addr_3), .ldr_wdata(ldr_wdata_3),
      .ldr_gnt(ldr_gnt_3), .ldr_rvalid(ldr_rvalid_3), .ldr_rdata(ldr_rdata_3),
      .ram_addr(ram_addr_3), .ram_wdata(ram_wdata_3), .ram_we(ram_we_3),
      .ram_rdata(ram_rdata_3), .busy(busy_3)
   );

   // RAM models: address sampled at an edge, data valid RAM_LAT edges later.
   logic        pre_we;
   logic [8:0]  pre_addr;
   logic [31:0] pre_data;
   logic [31:0] mem1 [512];
   logic [31:0] mem3 [512];
   logic [31:0] pipe1;
   logic [31:0] pipe3 [3];

   always @(posedge Clock) begin
      if (pre_we) mem1[pre_addr] <= pre_data;
      else if (ram_we) mem1[ram_addr] <= ram_wdata;
      pipe1 <= mem1[ram_addr];
   end
   assign ram_rdata = pipe1;

   always @(posedge Clock) begin
      if (pre_we) mem3[pre_addr] <= pre_data;
      else if (ram_we_3) mem3[ram_addr_3] <= ram_wdata_3;
      pipe3[0] <= mem3[ram_addr_3];
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end
   assign ram_rdata_3 = pipe3[2];

   int n_cpu_gnt = 0, n_both_gnt = 0, n_both_rv = 0, n_ram_we = 0;
   int n_cpu_rv = 0, n_ldr_rv = 0, n_busy3 = 0;
   always @(negedge Clock) begin
      n_cpu_gnt  <= n_cpu_gnt + int'(cpu_gnt);
      n_both_gnt <= n_both_gnt + int'(cpu_gnt && ldr_gnt);
      n_both_rv  <= n_both_rv + int'(cpu_rvalid && ldr_rvalid);
      n_ram_we   <= n_ram_we + int'(ram_we);
      n_cpu_rv   <= n_cpu_rv + int'(cpu_rvalid);
      n_ldr_rv   <= n_ldr_rv + int'(ldr_rvalid);
      n_busy3    <= n_busy3 + int'(busy_3);
   end

   // Reference model: shadow memory plus who was served last (0=CPU, 1=LDR).
   logic [31:0] ref_mem [512];
   logic        model_last;

   int          c_g, c_v, l_g, l_v;
   logic [31:0] c_rd, l_rd;

   function automatic logic [31:0] init_word(input int a);
      return 32'hA5A5_0000 ^ (a * 32'h0001_0003) ^ 32'h0000_0101;
   endfunction

   task automatic cpu_do(input logic we, input logic [8:0] a, input logic [31:0] d);
      int n;
      c_g = -1; c_v = -1; c_rd = '0;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
      n = 0;
      do begin @(negedge Clock); n++; end while (!cpu_gnt && n < 200);
      if (!cpu_gnt) begin
         checks++; errors++;
         $display("FAIL cpu_gnt_timeout got 0 want 1");
         cpu_req = 1'b0;
         return;
      end
      c_g = cyc;
      @(posedge Clock); #1 cpu_req = 1'b0;
      if (!we) begin
         n = 0;
         do begin @(negedge Clock); n++; end while (!cpu_rvalid && n < 20);
         if (!cpu_rvalid) begin
            checks++; errors++;
            $display("FAIL cpu_rvalid_timeout got 0 want 1");
         end else begin
            c_v = cyc; c_rd = cpu_rdata;
         end
      end
   endtask

   task automatic ldr_do(input logic we, input logic [8:0] a, input logic [31:0] d);
      int n;
      l_g = -1; l_v = -1; l_rd = '0;
      ldr_req = 1'b1; ldr_we = we; ldr_addr = a; ldr_wdata = d;
      n = 0;
      do begin @(negedge Clock); n++; end while (!ldr_gnt && n < 200);
      if (!ldr_gnt) begin
         checks++; errors++;
         $display("FAIL ldr_gnt_timeout got 0 want 1");
         ldr_req = 1'b0;
         return;
      end
      l_g = cyc;
      @(posedge Clock); #1 ldr_req = 1'b0;
      if (!we) begin
         n = 0;
         do begin @(negedge Clock); n++; end while (!ldr_rvalid && n < 20);
         if (!ldr_rvalid) begin
            checks++; errors++;
            $display("FAIL ldr_rvalid_timeout got 0 want 1");
         end else begin
            l_v = cyc; l_rd = ldr_rdata;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge Clock);
      checks++; if (cpu_gnt !== 1'b0) begin errors++; $display("FAIL rst_cpu_gnt got %b want 0", cpu_gnt); end
      checks++; if (ldr_gnt !== 1'b0) begin errors++; $display("FAIL rst_ldr_gnt got %b want 0", ldr_gnt); end
      checks++; if ({cpu_rvalid, ldr_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_rvalid got %b want 00", {cpu_rvalid, ldr_rvalid}); end
      checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we got %b want 0", ram_we); end
      checks++; if (ram_addr !== 9'h000) begin errors++; $display("FAIL rst_ram_addr got %h want 000", ram_addr); end
      checks++; if (ram_wdata !== 32'h0) begin errors++; $display("FAIL rst_ram_wdata got %h want 0", ram_wdata); end
      checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL rst_cpu_rdata got %h want 0", cpu_rdata); end
      checks++; if (ldr_rdata !== 32'h0) begin errors++; $display("FAIL rst_ldr_rdata got %h want 0", ldr_rdata); end
      checks++; if (busy !== 1'b0 || busy_3 !== 1'b0) begin errors++; $display("FAIL rst_busy got %b%b want 00", busy, busy_3); end
   endtask

   task automatic test_contention();
      int cg [2];
      int lg [2];
      logic [31:0] crd [2];
      logic [31:0] lrd [2];
      int both_snap;
      both_snap = n_both_gnt;
      @(posedge Clock); #1;
      fork
         begin
            for (int i = 0; i < 2; i++) begin cpu_do(1'b0, 9'h001, 32'h0); cg[i] = c_g; crd[i] = c_rd; end
         end
         begin
            for (int i = 0; i < 2; i++) begin ldr_do(1'b0, 9'h002, 32'h0); lg[i] = l_g; lrd[i] = l_rd; end
         end
      join
      // From reset the CPU wins first, then strict alternation at read spacing.
      checks++; if (lg[0] - cg[0] !== 4) begin errors++; $display("FAIL cont_order1 got %0d want 4", lg[0] - cg[0]); end
      checks++; if (cg[1] - lg[0] !== 4) begin errors++; $display("FAIL cont_order2 got %0d want 4", cg[1] - lg[0]); end
      checks++; if (lg[1] - cg[1] !== 4) begin errors++; $display("FAIL cont_order3 got %0d want 4", lg[1] - cg[1]); end
      for (int i = 0; i < 2; i++) begin
         checks++; if (crd[i] !== ref_mem[1]) begin errors++; $display("FAIL cont_cpu_data got %h want %h", crd[i], ref_mem[1]); end
         checks++; if (lrd[i] !== ref_mem[2]) begin errors++; $display("FAIL cont_ldr_data got %h want %h", lrd[i], ref_mem[2]); end
      end
      @(posedge Clock); #1;
      checks++; if (n_both_gnt - both_snap !== 0) begin errors++; $display("FAIL cont_dual_gnt got %0d want 0", n_both_gnt - both_snap); end
      model_last = 1'b1;
   endtask

   task automatic test_cpu_read();
      int gnt_snap, lrv_snap;
      @(posedge Clock); #1;
      gnt_snap = n_cpu_gnt; lrv_snap = n_ldr_rv;
      cpu_do(1'b0, 9'h010, 32'h0);
      checks++; if (c_rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data got %h want deadbeef", c_rd); end
      checks++; if (c_v - c_g !== 2) begin errors++; $display("FAIL rd_latency got %0d want 2", c_v - c_g); end
      @(posedge Clock); #1;
      checks++; if (n_cpu_gnt - gnt_snap !== 1) begin errors++; $display("FAIL rd_gnt_width got %0d want 1", n_cpu_gnt - gnt_snap); end
      checks++; if (n_ldr_rv - lrv_snap !== 0) begin errors++; $display("FAIL rd_ldr_rvalid got %0d want 0", n_ldr_rv - lrv_snap); end
      checks++; if (ldr_rdata !== ref_mem[2]) begin errors++; $display("FAIL rd_ldr_rdata got %h want %h", ldr_rdata, ref_mem[2]); end
      model_last = 1'b0;
   endtask

   task automatic test_write_read();
      int we_snap;
      @(posedge Clock); #1;
      we_snap = n_ram_we;
      ldr_do(1'b1, 9'h1FF, 32'h0000_1234);
      ref_mem[9'h1FF] = 32'h0000_1234;
      repeat (2) @(posedge Clock); #1;
      checks++; if (n_ram_we - we_snap !== 1) begin errors++; $display("FAIL wr_we_width got %0d want 1", n_ram_we - we_snap); end
      cpu_do(1'b0, 9'h1FF, 32'h0);
      checks++; if (c_rd !== 32'h0000_1234) begin errors++; $display("FAIL wr_readback got %h want 00001234", c_rd); end
      model_last = 1'b0;
   endtask

   task automatic test_random();
      for (int r = 0; r < 16; r++) begin
         logic con, lon, cwe, lwe, first, both, first_rd;
         logic [8:0] ca, la;
         logic [31:0] cd, ldd, exp_c, exp_l;
         int we_snap, nw, gap;
         con = 1'($urandom_range(0, 1));
         lon = con ? 1'($urandom_range(0, 1)) : 1'b1;
         cwe = 1'($urandom_range(0, 1));
         lwe = 1'($urandom_range(0, 1));
         ca  = 9'($urandom_range(0, 15));
         la  = 9'($urandom_range(0, 15));
         cd  = $urandom;
         ldd = $urandom;
         both = con && lon;
         first = both ? ~model_last : ~con;
         exp_c = '0; exp_l = '0;
         if (first == 1'b0) begin
            if (cwe) ref_mem[ca] = cd; else exp_c = ref_mem[ca];
            if (lon) begin if (lwe) ref_mem[la] = ldd; else exp_l = ref_mem[la]; end
         end else begin
            if (lwe) ref_mem[la] = ldd; else exp_l = ref_mem[la];
            if (con) begin if (cwe) ref_mem[ca] = cd; else exp_c = ref_mem[ca]; end
         end
         model_last = both ? ~first : first;
         nw = int'(con && cwe) + int'(lon && lwe);
         first_rd = first ? ~lwe : ~cwe;
         @(posedge Clock); #1;
         we_snap = n_ram_we;
         fork
            begin if (con) cpu_do(cwe, ca, cd); end
            begin if (lon) ldr_do(lwe, la, ldd); end
         join
         @(posedge Clock); #1;
         if (con && !cwe) begin
            checks++; if (c_rd !== exp_c || c_v - c_g !== 2) begin errors++; $display("FAIL rnd_cpu_read got %h/%0d want %h/2", c_rd, c_v - c_g, exp_c); end
         end
         if (lon && !lwe) begin
            checks++; if (l_rd !== exp_l || l_v - l_g !== 2) begin errors++; $display("FAIL rnd_ldr_read got %h/%0d want %h/2", l_rd, l_v - l_g, exp_l); end
         end
         if (both) begin
            gap = first ? (c_g - l_g) : (l_g - c_g);
            checks++; if (gap !== (first_rd ? 4 : 2)) begin errors++; $display("FAIL rnd_gap got %0d want %0d", gap, first_rd ? 4 : 2); end
         end
         checks++; if (n_ram_we - we_snap !== nw) begin errors++; $display("FAIL rnd_we_count got %0d want %0d", n_ram_we - we_snap, nw); end
      end
   endtask

   task automatic test_stop();
      int k, n;
      @(posedge Clock); #1;
      fork
         ldr_do(1'b0, 9'h020, 32'h0);
         begin
            n = 0;
            do begin @(negedge Clock); n++; end while (!ldr_gnt && n < 50);
            @(posedge Clock); #1;
            Stop = 1'b1;
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h030; cpu_wdata = 32'h0;
         end
      join
      checks++; if (l_rd !== ref_mem[9'h020]) begin errors++; $display("FAIL stop_ldr_data got %h want %h", l_rd, ref_mem[9'h020]); end
      for (int i = 0; i < 10; i++) begin
         @(negedge Clock);
         checks++; if (busy !== 1'b0 || cpu_gnt !== 1'b0) begin errors++; $display("FAIL stop_hold got busy=%b gnt=%b want 0/0", busy, cpu_gnt); end
      end
      @(posedge Clock); #1;
      Stop = 1'b0;
      k = cyc;
      n = 0;
      do begin @(negedge Clock); n++; end while (!cpu_gnt && n < 20);
      checks++; if (!cpu_gnt || cyc !== k + 1) begin errors++; $display("FAIL stop_release got cyc %0d want %0d", cyc, k + 1); end
      @(posedge Clock); #1 cpu_req = 1'b0;
      n = 0;
      do begin @(negedge Clock); n++; end while (!cpu_rvalid && n < 20);
      checks++; if (cpu_rdata !== ref_mem[9'h030]) begin errors++; $display("FAIL stop_cpu_data got %h want %h", cpu_rdata, ref_mem[9'h030]); end
      model_last = 1'b0;
   endtask

   task automatic test_reset_mid();
      int n, rv_snap;
      @(posedge Clock); #1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h033;
      n = 0;
      do begin @(negedge Clock); n++; end while (!cpu_gnt && n < 20);
      @(posedge Clock); #1;
      Reset = 1'b1;
      cpu_req = 1'b0;
      rv_snap = n_cpu_rv;
      #1;
      checks++; if (busy !== 1'b0 || ram_we !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b/%b want 0/0", busy, ram_we); end
      checks++; if (cpu_rdata !== 32'h0 || ldr_rdata !== 32'h0) begin errors++; $display("FAIL rmid_rdata got %h/%h want 0/0", cpu_rdata, ldr_rdata); end
      checks++; if (ram_addr !== 9'h0) begin errors++; $display("FAIL rmid_ram_addr got %h want 000", ram_addr); end
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
      repeat (4) @(posedge Clock); #1;
      checks++; if (n_cpu_rv - rv_snap !== 0) begin errors++; $display("FAIL rmid_no_rvalid got %0d want 0", n_cpu_rv - rv_snap); end
      model_last = 1'b1;
      fork
         cpu_do(1'b0, 9'h005, 32'h0);
         ldr_do(1'b0, 9'h006, 32'h0);
      join
      checks++; if (l_g - c_g !== 4) begin errors++; $display("FAIL rmid_cpu_first got %0d want 4", l_g - c_g); end
      model_last = 1'b1;
   endtask

   task automatic test_lat3();
      int n, g, busy_snap;
      @(posedge Clock); #1;
      busy_snap = n_busy3;
      cpu_req_3 = 1'b1; cpu_we_3 = 1'b0; cpu_addr_3 = 9'h055;
      n = 0;
      do begin @(negedge Clock); n++; end while (!cpu_gnt_3 && n < 20);
      g = cyc;
      @(posedge Clock); #1 cpu_req_3 = 1'b0;
      n = 0;
      do begin @(negedge Clock); n++; end while (!cpu_rvalid_3 && n < 20);
      checks++; if (!cpu_rvalid_3 || cyc - g !== 4) begin errors++; $display("FAIL lat3_latency got %0d want 4", cyc - g); end
      checks++; if (cpu_rdata_3 !== init_word(9'h055)) begin errors++; $display("FAIL lat3_data got %h want %h", cpu_rdata_3, init_word(9'h055)); end
      repeat (3) @(posedge Clock); #1;
      checks++; if (n_busy3 - busy_snap !== 5) begin errors++; $display("FAIL lat3_busy got %0d want 5", n_busy3 - busy_snap); end
   endtask

   initial begin
      Reset = 1'b1; Stop = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
      cpu_req_3 = 1'b0; cpu_we_3 = 1'b0; cpu_addr_3 = '0; cpu_wdata_3 = '0;
      ldr_req_3 = 1'b0; ldr_we_3 = 1'b0; ldr_addr_3 = '0; ldr_wdata_3 = '0;
      model_last = 1'b1;
      for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);
      ref_mem[9'h010] = 32'hDEAD_BEEF;
      @(posedge Clock); #1;
      pre_we = 1'b1;
      for (int i = 0; i < 512; i++) begin
         pre_addr = 9'(i); pre_data = (i == 16) ? 32'hDEAD_BEEF : init_word(i);
         @(posedge Clock); #1;
      end
      pre_we = 1'b0;
      Reset = 1'b0;
      test_reset();
      test_contention();
      test_cpu_read();
      test_write_read();
      test_random();
      test_stop();
      test_reset_mid();
      test_lat3();
      checks++; if (n_both_gnt !== 0 || n_both_rv !== 0) begin errors++; $display("FAIL exclusive got %0d/%0d want 0/0", n_both_gnt, n_both_rv); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
